// File: rtl/ctrl_regfile_pkg.sv
// Shared constants, FSM state types and the address-region decoder for the
// AXI4-Lite control register file.
package ctrl_regfile_pkg;

    localparam logic [31:0] CTRL_OFS  = 32'h0000_0000;
    localparam logic [31:0] GIE_OFS   = 32'h0000_0004;
    localparam logic [31:0] IER_OFS   = 32'h0000_0008;
    localparam logic [31:0] ISR_OFS   = 32'h0000_000C;
    localparam logic [31:0] USER_BASE = 32'h0000_0010;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    typedef enum logic [2:0] {
        REG_CTRL, REG_GIE, REG_IER, REG_ISR, REG_USER, REG_STAT, REG_BAD
    } region_e;

    // Classify a word index; user registers follow USER_BASE, status follows user.
    function automatic region_e decode_region(input logic [31:0] widx,
                                              input int unsigned nwr,
                                              input int unsigned nrd);
        logic [31:0] user_lo;
        logic [31:0] stat_lo;
        region_e     r;
        user_lo = USER_BASE >> 2;
        stat_lo = user_lo + 32'(nwr);
        if (widx == (CTRL_OFS >> 2))                         r = REG_CTRL;
        else if (widx == (GIE_OFS >> 2))                     r = REG_GIE;
        else if (widx == (IER_OFS >> 2))                     r = REG_IER;
        else if (widx == (ISR_OFS >> 2))                     r = REG_ISR;
        else if (widx >= user_lo && widx < stat_lo)          r = REG_USER;
        else if (widx >= stat_lo && widx < stat_lo + 32'(nrd)) r = REG_STAT;
        else                                                 r = REG_BAD;
        return r;
    endfunction

endpackage

// File: rtl/axi_lite_wstrb_merge.sv
// Byte-masked merge of an old and a new 32-bit word under a 4-bit strobe.
module axi_lite_wstrb_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  strb,
    output logic [31:0] merged
);

    // Take each byte from the new word only where its strobe is set.
    always_comb begin
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
            else         merged[8*b +: 8] = old_word[8*b +: 8];
        end
    end

endmodule

// File: rtl/axi_lite_ctrl_regfile.sv
// AXI4-Lite control slave: ap_ctrl handshake, NUM_WR RW and NUM_RD RO registers.
// Optional interrupt block (GIE/IER/ISR + interrupt port) under CTRL_REGFILE_IRQ_EN.
module axi_lite_ctrl_regfile
    import ctrl_regfile_pkg::*;
#(
    parameter int          ADDR_W       = 12,
    parameter int          NUM_WR       = 8,
    parameter int          NUM_RD       = 4,
    parameter logic [31:0] WR_RESET_VAL = 32'h0
) (
    input  logic                                   ap_clk,
    input  logic                                   ap_rst_n,
    input  logic                                   s_axi_control_AWVALID,
    output logic                                   s_axi_control_AWREADY,
    input  logic [ADDR_W-1:0]                      s_axi_control_AWADDR,
    input  logic                                   s_axi_control_WVALID,
    output logic                                   s_axi_control_WREADY,
    input  logic [31:0]                            s_axi_control_WDATA,
    input  logic [3:0]                             s_axi_control_WSTRB,
    output logic                                   s_axi_control_BVALID,
    input  logic                                   s_axi_control_BREADY,
    output logic [1:0]                             s_axi_control_BRESP,
    input  logic                                   s_axi_control_ARVALID,
    output logic                                   s_axi_control_ARREADY,
    input  logic [ADDR_W-1:0]                      s_axi_control_ARADDR,
    output logic                                   s_axi_control_RVALID,
    input  logic                                   s_axi_control_RREADY,
    output logic [31:0]                            s_axi_control_RDATA,
    output logic [1:0]                             s_axi_control_RRESP,
`ifdef CTRL_REGFILE_IRQ_EN
    output logic                                   interrupt,
`endif
    output logic                                   ap_start,
    input  logic                                   ap_done,
    input  logic                                   ap_idle,
    output logic [32*NUM_WR-1:0]                   wr_regs,
    input  logic [32*((NUM_RD > 0) ? NUM_RD : 1)-1:0] rd_regs
);

    localparam int USER_IDX = int'(USER_BASE >> 2);
    localparam int STAT_IDX = USER_IDX + NUM_WR;

    wstate_e            wstate_r;
    rstate_e            rstate_r;
    logic               awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
    logic [1:0]         bresp_r, rresp_r;
    logic [31:0]        rdata_r;
    logic               aw_held_r, w_held_r;
    logic [ADDR_W-1:0]  awaddr_r;
    logic [31:0]        wdata_r;
    logic [3:0]         wstrb_r;
    logic               ap_start_r, done_latch_r;

    logic               aw_hs_s, w_hs_s, ar_hs_s, commit_s, ctrl_we_s;
    logic [ADDR_W-1:0]  wa_s;
    logic [31:0]        wd_s, widx_w_s, widx_r_s, rd_word_s;
    logic [3:0]         ws_s;
    logic [1:0]         rd_resp_s;
    region_e            wreg_s, rreg_s;
    logic               addr_lsb_unused_s;

    assign aw_hs_s  = s_axi_control_AWVALID & awready_r;
    assign w_hs_s   = s_axi_control_WVALID & wready_r;
    assign ar_hs_s  = s_axi_control_ARVALID & arready_r;
    assign commit_s = (wstate_r == W_IDLE) & (aw_held_r | aw_hs_s) & (w_held_r | w_hs_s);

    // Use the captured AW/W beat if one arrived earlier, else the live bus.
    always_comb begin
        if (aw_held_r) wa_s = awaddr_r;
        else           wa_s = s_axi_control_AWADDR;
        if (w_held_r) begin
            wd_s = wdata_r;
            ws_s = wstrb_r;
        end else begin
            wd_s = s_axi_control_WDATA;
            ws_s = s_axi_control_WSTRB;
        end
    end

    assign widx_w_s  = 32'(wa_s[ADDR_W-1:2]);
    assign widx_r_s  = 32'(s_axi_control_ARADDR[ADDR_W-1:2]);
    assign wreg_s    = decode_region(widx_w_s, NUM_WR, NUM_RD);
    assign rreg_s    = decode_region(widx_r_s, NUM_WR, NUM_RD);
    assign ctrl_we_s = commit_s & (wreg_s == REG_CTRL) & ws_s[0];
    assign addr_lsb_unused_s = ^{wa_s[1:0], s_axi_control_ARADDR[1:0]};

    // User registers, each with its own strobe merge.
    for (genvar i = 0; i < NUM_WR; i++) begin : g_user
        logic [31:0] val_r;
        logic [31:0] merged_s;
        logic        we_s;

        axi_lite_wstrb_merge u_merge (
            .old_word (val_r),
            .new_word (wd_s),
            .strb     (ws_s),
            .merged   (merged_s)
        );

        assign we_s = commit_s && (widx_w_s == 32'(USER_IDX + i));

        // Register update on a committed write to this slot.
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n)  val_r <= WR_RESET_VAL;
            else if (we_s)  val_r <= merged_s;
            else            val_r <= val_r;
        end

        assign wr_regs[32*i +: 32] = val_r;
    end

`ifdef CTRL_REGFILE_IRQ_EN
    logic       gie_r, interrupt_r;
    logic [1:0] ier_r, isr_r, isr_set_s, isr_tgl_s;

    // ISR bit1 is set on the edge where a start write is accepted from idle.
    always_comb begin
        isr_set_s = {ctrl_we_s & wd_s[0] & ~ap_start_r, ap_done};
        if (commit_s && wreg_s == REG_ISR && ws_s[0]) isr_tgl_s = wd_s[1:0];
        else                                          isr_tgl_s = 2'b00;
    end

    // Interrupt enable/status registers and registered interrupt output.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            gie_r       <= 1'b0;
            ier_r       <= 2'b00;
            isr_r       <= 2'b00;
            interrupt_r <= 1'b0;
        end else begin
            if (commit_s && wreg_s == REG_GIE && ws_s[0]) gie_r <= wd_s[0];
            if (commit_s && wreg_s == REG_IER && ws_s[0]) ier_r <= wd_s[1:0];
            isr_r       <= (isr_r ^ isr_tgl_s) | isr_set_s;
            interrupt_r <= gie_r & (|(ier_r & isr_r));
        end
    end

    assign interrupt = interrupt_r;
`endif

    // Read mux: returns the pre-write contents of the addressed register.
    always_comb begin
        rd_word_s = 32'h0;
        rd_resp_s = RESP_OKAY;
        case (rreg_s)
            REG_CTRL: rd_word_s = {29'h0, ap_idle, done_latch_r, ap_start_r};
`ifdef CTRL_REGFILE_IRQ_EN
            REG_GIE:  rd_word_s = {31'h0, gie_r};
            REG_IER:  rd_word_s = {30'h0, ier_r};
            REG_ISR:  rd_word_s = {30'h0, isr_r};
`endif
            REG_USER: begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (widx_r_s == 32'(USER_IDX + i)) rd_word_s = wr_regs[32*i +: 32];
                    else                               rd_word_s = rd_word_s;
                end
            end
            REG_STAT: begin
                for (int j = 0; j < NUM_RD; j++) begin
                    if (widx_r_s == 32'(STAT_IDX + j)) rd_word_s = rd_regs[32*j +: 32];
                    else                               rd_word_s = rd_word_s;
                end
            end
            REG_BAD:  rd_resp_s = RESP_SLVERR;
            default:  rd_word_s = 32'h0;
        endcase
    end

    // ap_start / done_latch: a start write beats a coincident ap_done, and
    // ap_done beats a coincident clear-on-read.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ap_start_r   <= 1'b0;
            done_latch_r <= 1'b0;
        end else begin
            if (ctrl_we_s)    ap_start_r <= wd_s[0];
            else if (ap_done) ap_start_r <= 1'b0;
            else              ap_start_r <= ap_start_r;
            if (ap_done)                               done_latch_r <= 1'b1;
            else if (ar_hs_s && rreg_s == REG_CTRL)    done_latch_r <= 1'b0;
            else                                       done_latch_r <= done_latch_r;
        end
    end

    // Write channel FSM; READYs come up one cycle after reset release.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wstate_r  <= W_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            awaddr_r  <= '0;
            wdata_r   <= 32'h0;
            wstrb_r   <= 4'h0;
        end else begin
            case (wstate_r)
                W_IDLE: begin
                    if (commit_s) begin
                        wstate_r  <= W_RESP;
                        bvalid_r  <= 1'b1;
                        bresp_r   <= (wreg_s == REG_BAD) ? RESP_SLVERR : RESP_OKAY;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b0;
                        aw_held_r <= 1'b0;
                        w_held_r  <= 1'b0;
                    end else begin
                        if (aw_hs_s) begin
                            aw_held_r <= 1'b1;
                            awaddr_r  <= s_axi_control_AWADDR;
                        end
                        if (w_hs_s) begin
                            w_held_r <= 1'b1;
                            wdata_r  <= s_axi_control_WDATA;
                            wstrb_r  <= s_axi_control_WSTRB;
                        end
                        awready_r <= ~(aw_held_r | aw_hs_s);
                        wready_r  <= ~(w_held_r | w_hs_s);
                    end
                end
                W_RESP: begin
                    if (s_axi_control_BREADY) begin
                        wstate_r  <= W_IDLE;
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        wready_r  <= 1'b1;
                    end
                end
                default: begin
                    wstate_r <= W_IDLE;
                    bvalid_r <= 1'b0;
                end
            endcase
        end
    end

    // Read channel FSM with one-cycle registered data latency.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rstate_r  <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'h0;
            rresp_r   <= RESP_OKAY;
        end else begin
            case (rstate_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        rstate_r  <= R_DATA;
                        rdata_r   <= rd_word_s;
                        rresp_r   <= rd_resp_s;
                        rvalid_r  <= 1'b1;
                        arready_r <= 1'b0;
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_control_RREADY) begin
                        rstate_r  <= R_IDLE;
                        rvalid_r  <= 1'b0;
                        arready_r <= 1'b1;
                    end
                end
                default: begin
                    rstate_r <= R_IDLE;
                    rvalid_r <= 1'b0;
                end
            endcase
        end
    end

    assign s_axi_control_AWREADY = awready_r;
    assign s_axi_control_WREADY  = wready_r;
    assign s_axi_control_BVALID  = bvalid_r;
    assign s_axi_control_BRESP   = bresp_r;
    assign s_axi_control_ARREADY = arready_r;
    assign s_axi_control_RVALID  = rvalid_r;
    assign s_axi_control_RDATA   = rdata_r;
    assign s_axi_control_RRESP   = rresp_r;
    assign ap_start              = ap_start_r;

endmodule

// File: tb/tb_axi_lite_ctrl_regfile.sv
// Directed self-checking bench for axi_lite_ctrl_regfile (ADDR_W=16, NUM_WR=8, NUM_RD=4).
module tb_axi_lite_ctrl_regfile;

    localparam int ADDR_W = 16;
    localparam int NUM_WR = 8;
    localparam int NUM_RD = 4;

    logic                 ap_clk = 1'b0;
    logic                 ap_rst_n = 1'b0;
    logic                 awvalid, awready, wvalid, wready, bvalid, bready;
    logic                 arvalid, arready, rvalid, rready;
    logic [ADDR_W-1:0]    awaddr, araddr;
    logic [31:0]          wdata, rdata;
    logic [3:0]           wstrb;
    logic [1:0]           bresp, rresp;
    logic                 ap_start, ap_done, ap_idle;
    logic [32*NUM_WR-1:0] wr_regs;
    logic [32*NUM_RD-1:0] rd_regs;
`ifdef CTRL_REGFILE_IRQ_EN
    logic                 interrupt;
`endif

    int checks = 0;
    int errors = 0;

    axi_lite_ctrl_regfile #(
        .ADDR_W(ADDR_W), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD), .WR_RESET_VAL(32'h0)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_axi_control_AWVALID(awvalid), .s_axi_control_AWREADY(awready),
        .s_axi_control_AWADDR(awaddr),
        .s_axi_control_WVALID(wvalid), .s_axi_control_WREADY(wready),
        .s_axi_control_WDATA(wdata), .s_axi_control_WSTRB(wstrb),
        .s_axi_control_BVALID(bvalid), .s_axi_control_BREADY(bready),
        .s_axi_control_BRESP(bresp),
        .s_axi_control_ARVALID(arvalid), .s_axi_control_ARREADY(arready),
        .s_axi_control_ARADDR(araddr),
        .s_axi_control_RVALID(rvalid), .s_axi_control_RREADY(rready),
        .s_axi_control_RDATA(rdata), .s_axi_control_RRESP(rresp),
`ifdef CTRL_REGFILE_IRQ_EN
        .interrupt(interrupt),
`endif
        .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
        .wr_regs(wr_regs), .rd_regs(rd_regs)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int   n;
        logic aw_pend, w_pend, aw_hs, w_hs;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; aw_pend = 1'b1; w_pend = 1'b1; n = 0;
        while ((aw_pend || w_pend) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick(); n++;
            if (aw_hs) begin awvalid = 1'b0; aw_pend = 1'b0; end
            if (w_hs)  begin wvalid = 1'b0;  w_pend = 1'b0;  end
        end
        chk("wr_accept_timeout", {aw_pend, w_pend}, 2'b00);
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        chk("wr_bvalid_timeout", bvalid, 1'b1);
        resp = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        int   n;
        logic pend, hs;
        araddr = a; arvalid = 1'b1; pend = 1'b1; n = 0;
        while (pend && n < 20) begin
            hs = arvalid && arready;
            tick(); n++;
            if (hs) begin arvalid = 1'b0; pend = 1'b0; end
        end
        chk("rd_accept_timeout", pend, 1'b0);
        n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        chk("rd_rvalid_timeout", rvalid, 1'b1);
        d = rdata;
        resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; araddr = '0; wdata = 32'h0; wstrb = 4'h0;
        ap_done = 1'b0; ap_idle = 1'b0; rd_regs = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_resp", {bresp, rresp}, 4'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ap_start", ap_start, 1'b0);
        chk("rst_wr_regs", wr_regs, 256'h0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        chk("ready_low_after_release", {awready, wready, arready}, 3'b000);
        tick();
        chk("ready_high_after_release", {awready, wready, arready}, 3'b111);

        // AW in cycle 0, W in cycle 3
        awaddr = 16'h0010; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("aw_first_ready", {awready, wready}, 2'b01);
        tick(); tick();
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        chk("aw_first_no_bvalid", bvalid, 1'b0);
        tick();
        wvalid = 1'b0;
        chk("aw_first_bvalid", bvalid, 1'b1);
        chk("aw_first_bresp", bresp, 2'b00);
        chk("aw_first_reg0", wr_regs[31:0], 32'hDEADBEEF);
        chk("w_resp_readies", {awready, wready}, 2'b00);
        tick();
        chk("bvalid_held", bvalid, 1'b1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bvalid_cleared", {bvalid, awready, wready}, 3'b011);

        // Byte-strobe merge
        axi_write(16'h0014, 32'h11223344, 4'hF, resp);
        chk("reg1_full_resp", resp, 2'b00);
        axi_write(16'h0014, 32'h0000AB00, 4'h2, resp);
        chk("reg1_strb_value", wr_regs[63:32], 32'h1122AB44);

        // Simultaneous write and read of the same register
        awaddr = 16'h0018; wdata = 32'h00000055; wstrb = 4'hF; araddr = 16'h0018;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("rw_same_rdata_old", {rvalid, rdata}, {1'b1, 32'h0});
        chk("rw_same_reg2_new", wr_regs[95:64], 32'h00000055);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;

        // Status read with RREADY held low for 5 cycles
        rd_regs[63:32] = 32'hCAFEF00D;
        araddr = 16'h0034; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        rd_regs[63:32] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("stat_hold", {rvalid, arready, rresp, rdata}, {1'b1, 1'b0, 2'b00, 32'hCAFEF00D});
            tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("stat_rvalid_cleared", {rvalid, arready}, 2'b01);

        // ap_ctrl handshake and done latch
        axi_write(16'h0000, 32'h1, 4'h1, resp);
        chk("ctrl_start_set", {ap_start, resp}, 3'b100);
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        chk("ctrl_start_cleared", ap_start, 1'b0);
        axi_read(16'h0000, d, resp);
        chk("ctrl_read1", d, 32'h2);
        axi_read(16'h0000, d, resp);
        chk("ctrl_read2", d, 32'h0);

        // ap_done coincident with CTRL read keeps the latch
        ap_idle = 1'b1;
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        araddr = 16'h0000; arvalid = 1'b1; ap_done = 1'b1;
        tick();
        arvalid = 1'b0; ap_done = 1'b0;
        chk("ctrl_done_race_rdata", rdata, 32'h6);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        axi_read(16'h0000, d, resp);
        chk("ctrl_done_race_kept", d, 32'h6);
        axi_read(16'h0000, d, resp);
        chk("ctrl_done_race_cleared", d, 32'h4);

        // Start write coincident with ap_done: write wins
        awaddr = 16'h0000; wdata = 32'h1; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
        ap_done = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; ap_done = 1'b0;
        chk("ctrl_write_wins", ap_start, 1'b1);
        bready = 1'b1;
        tick();
        bready = 1'b0;

        // Reserved / status writes and out-of-range accesses
        axi_read(16'h0004, d, resp);
        chk("rsvd_read", {resp, d}, {2'b00, 32'h0});
        axi_write(16'h0030, 32'h12345678, 4'hF, resp);
        chk("stat_write_okay", resp, 2'b00);
        axi_write(16'h1000, 32'hFFFFFFFF, 4'hF, resp);
        chk("oor_bresp", resp, 2'b10);
        axi_read(16'h1000, d, resp);
        chk("oor_read", {resp, d}, {2'b10, 32'h0});
        chk("oor_regs_unchanged", wr_regs,
            {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000055, 32'h1122AB44, 32'hDEADBEEF});

        // Reset while BVALID is pending
        awaddr = 16'h001C; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("pre_reset_bvalid", {bvalid, wr_regs[127:96]}, {1'b1, 32'h77});
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("mid_reset_bvalid", bvalid, 1'b0);
        chk("mid_reset_regs", wr_regs, 256'h0);
        chk("mid_reset_outs", {awready, wready, arready, ap_start}, 4'b0000);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        chk("post_reset_ready_low", {awready, wready, arready}, 3'b000);
        tick();
        chk("post_reset_ready_high", {awready, wready, arready}, 3'b111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
